// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write bank.
package regfile_pkg;

  localparam int NREG  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(NREG);
  localparam int NBYTE = WIDTH / 8;

  localparam logic [AW-1:0] ZERO_REG = 5'd0;
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/regfile_write_bank_write_decoder.sv
// Write-address decoder: one-hot register enable, register 0 never selected.
module write_decoder
  import regfile_pkg::*;
(
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (addr != ZERO_REG)) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Register storage with byte-masked handshake writes and a sequenced bulk clear.
module regfile_write_bank
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [NBYTE-1:0]      wr_be,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic [NREG*WIDTH-1:0] regs_flat
);

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          clr_done_reg, clr_done_next;
  logic          accept;
  logic [NREG-1:0] wr_onehot;

  assign wr_ready = (state_reg == IDLE);
  assign busy     = (state_reg == CLEAR);
  assign clr_done = clr_done_reg;
  assign accept   = wr_valid && wr_ready;

  write_decoder u_decoder (
    .addr   (wr_addr),
    .en     (accept),
    .onehot (wr_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      clr_done_reg <= clr_done_next;
    end
  end

  // The counter stops at LAST_REG explicitly, so it never wraps back onto register 0.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt_reg == LAST_REG) begin
          state_next    = IDLE;
          cnt_next      = '0;
          clr_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign regs_flat[WIDTH-1:0] = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
    logic [WIDTH-1:0] q_reg;
    logic             clr_hit;

    assign clr_hit = busy && (cnt_reg == AW'(gi));

    // Writes and clears never coincide: writes are only accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_reg <= '0;
      end else if (clr_hit) begin
        q_reg <= '0;
      end else begin
        for (int k = 0; k < NBYTE; k++) begin
          if (wr_onehot[gi] && wr_be[k]) begin
            q_reg[k*8 +: 8] <= wr_data[k*8 +: 8];
          end
        end
      end
    end

    assign regs_flat[gi*WIDTH +: WIDTH] = q_reg;
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: vector table, scoreboard, clear corner cases.
module tb_regfile_write_bank;
  import regfile_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  wr_valid = 1'b0;
  logic                  clr_req = 1'b0;
  logic [AW-1:0]         wr_addr = '0;
  logic [WIDTH-1:0]      wr_data = '0;
  logic [NBYTE-1:0]      wr_be = '0;
  logic                  wr_ready, busy, clr_done;
  logic [NREG*WIDTH-1:0] regs_flat;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model [NREG];

  typedef struct {
    int          addr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  regfile_write_bank dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
    .regs_flat (regs_flat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [31:0] slot(input int r);
    return regs_flat[r*WIDTH +: WIDTH];
  endfunction

  function automatic int flat_diffs();
    int n = 0;
    for (int r = 0; r < NREG; r++) begin
      if (regs_flat[r*WIDTH +: WIDTH] !== model[r]) n++;
    end
    return n;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NREG; r++) model[r] = '0;
  endtask

  task automatic apply_model(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a != 5'd0) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
      end
    end
  endtask

  // Holds the request until wr_ready was seen before an edge; returns edges waited.
  task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                             output bit ok, output int n);
    n = 0;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be = be;
    while (!ok && n < 64) begin
      ok = wr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic write_and_check(input string name, input logic [4:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input logic [31:0] exp, output int w);
    sb_t e;
    bit  ok;
    e.addr = int'(a);
    e.exp  = exp;
    sb_q.push_back(e);
    drive_write(a, d, be, ok, w);
    if (!ok) begin
      check({name, "_handshake_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    apply_model(a, d, be);
    e = sb_q.pop_front();
    check(name, slot(e.addr), e.exp);
    check({name, "_others"}, 32'(flat_diffs()), 32'd0);
  endtask

  initial begin
    int w;
    int busy_cnt, done_cnt, done_at, ready_bad;

    vecs[0] = '{"full_write5",  5'd5,  32'hDEADBEEF, 4'hF,    32'hDEADBEEF};
    vecs[1] = '{"masked5",      5'd5,  32'h11223344, 4'b0101, 32'hDE22BE44};
    vecs[2] = '{"zero_reg",     5'd0,  32'hFFFFFFFF, 4'hF,    32'h00000000};
    vecs[3] = '{"be_none9",     5'd9,  32'h12345678, 4'h0,    32'h00000000};
    vecs[4] = '{"top_byte9",    5'd9,  32'hAABBCCDD, 4'b1000, 32'hAA000000};
    vecs[5] = '{"low_half31",   5'd31, 32'hCAFEF00D, 4'b0011, 32'h0000F00D};
    vecs[6] = '{"upper3_1",     5'd1,  32'h01020304, 4'b1110, 32'h01020300};

    clear_model();

    // Asynchronous reset: outputs settle before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_flat", 32'(flat_diffs()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      write_and_check(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp, w);
    end
    check("zero_reg_no_wait", 32'(busy), 32'd0);

    for (int r = 1; r < NREG; r++) begin
      write_and_check($sformatf("fill%0d", r), 5'(r), 32'(r), 4'hF, 32'(r), w);
    end

    // Clear request with a simultaneous write to register 7.
    wr_valid = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hA5A5A5A5;
    wr_be = 4'hF;
    clr_req = 1'b1;
    check("clr_start_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    clr_req = 1'b0;
    apply_model(5'd7, 32'hA5A5A5A5, 4'hF);
    check("clr_write7", slot(7), 32'hA5A5A5A5);
    busy_cnt = 0; done_cnt = 0; done_at = -1; ready_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (busy && wr_ready) ready_bad++;
      if (clr_done) begin
        done_cnt++;
        done_at = i;
        check("clr_done_ready", 32'(wr_ready), 32'd1);
        check("clr_done_busy", 32'(busy), 32'd0);
      end
      clr_req = (i == 5);
      @(posedge clk);
      #1;
    end
    clr_req = 1'b0;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_ready_low", 32'(ready_bad), 32'd0);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    check("clr_done_cycle", 32'(done_at), 32'd31);
    clear_model();
    check("clr_flat_zero", 32'(flat_diffs()), 32'd0);

    // Write held across a whole clear sequence.
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    write_and_check("held3", 5'd3, 32'h00000055, 4'hF, 32'h00000055, w);
    check("held3_wait_edges", 32'(w), 32'd32);

    // Reset in the middle of a clear.
    write_and_check("pre_rst20", 5'd20, 32'h20202020, 4'hF, 32'h20202020, w);
    write_and_check("pre_rst30", 5'd30, 32'h30303030, 4'hF, 32'h30303030, w);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("mid_clr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    clear_model();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(wr_ready), 32'd1);
    check("mid_rst_flat", 32'(flat_diffs()), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (clr_done) done_cnt++;
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_no_busy", 32'(busy_cnt), 32'd0);
    write_and_check("post_rst12", 5'd12, 32'h0BADF00D, 4'b0110, 32'h00ADF000, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
